// File: rtl/logic_pipe_pkg.sv
// logic_pipe_pkg: function-mode encoding and the per-bit x/y evaluation shared by the pipe
package logic_pipe_pkg;
  typedef enum logic [1:0] {
    MODE_LAB  = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_MUX  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;
  function automatic logic [1:0] eval(input mode_e m, input logic a, input logic b, input logic c);
    logic ab;
    ab = a | b;
    return m == MODE_LAB ? {~c ^ ab, ab & (~(a & b) ^ ab)} :
           m == MODE_ADD ? {a ^ b ^ c, (a & b) | (a & c) | (b & c)} :
           m == MODE_MUX ? {c ? b : a, ~(ab | c)} :
                           {a, b};
  endfunction
endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage: one {valid, x, y} pipeline register, loaded whenever the top says it may advance
module logic_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y
);
  logic             r_valid;
  logic [WIDTH-1:0] r_x, r_y;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_x     <= i_x;
      r_y     <= i_y;
    end
  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: bitwise a/b/c -> x/y function unit with valid/ready pipeline and saturating txn counter
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] txn_count
);
  logic [WIDTH-1:0] w_fx, w_fy;
  logic [STAGES-1:0] w_v;
  logic [WIDTH-1:0] w_x [STAGES];
  logic [WIDTH-1:0] w_y [STAGES];
  logic [STAGES:0]   w_rdy;
  logic [CNT_W-1:0]  r_cnt;
  always_comb begin
    w_fx = '0;
    w_fy = '0;
    for (int i = 0; i < WIDTH; i++) {w_fx[i], w_fy[i]} = eval(mode_e'(mode), a[i], b[i], c[i]);
  end
  // a stage may load if it is empty or everything downstream of it moves this cycle
  always_comb begin
    w_rdy = '0;
    w_rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) w_rdy[k] = ~w_v[k] | w_rdy[k+1];
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_iv;
    logic [WIDTH-1:0] w_ix, w_iy;
    if (k == 0) begin : g_head
      assign w_iv = in_valid;
      assign w_ix = w_fx;
      assign w_iy = w_fy;
    end else begin : g_body
      assign w_iv = w_v[k-1];
      assign w_ix = w_x[k-1];
      assign w_iy = w_y[k-1];
    end
    logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_rdy[k]),
      .i_valid(w_iv),
      .i_x    (w_ix),
      .i_y    (w_iy),
      .o_valid(w_v[k]),
      .o_x    (w_x[k]),
      .o_y    (w_y[k])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (out_valid && out_ready && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign in_ready  = w_rdy[0];
  assign out_valid = w_v[STAGES-1];
  assign x         = w_x[STAGES-1];
  assign y         = w_y[STAGES-1];
  assign txn_count = r_cnt;
endmodule
